// File: rtl/rst_seq.sv
// Reset sequencer for the Selen CPU: stretches core reset, adds a quiet window
// before core_ready, and serves software and synchronised external reset requests.
module rst_seq #(
  parameter int HOLD_CYCLES = 16,
  parameter int POST_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_rst_req,
  input  logic             sw_rst_req,
  output logic             sw_rst_ack,
  output logic             core_rst,
  output logic             core_ready,
  output logic             rst_done,
  output logic [CNT_W-1:0] rst_count
);

  localparam int MAX_C = (HOLD_CYCLES > POST_CYCLES) ? HOLD_CYCLES : POST_CYCLES;
  localparam int CW    = $clog2(MAX_C) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POST_CYCLES - 1);

  typedef enum logic [1:0] {HOLD, POST, RUN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          ext_m, ext_s;
  logic          sw_pending, sw_pending_nx;
  logic          sw_armed, sw_armed_nx;
  logic          done_nx, ack_nx;

  // ext_rst_req is asynchronous to clk; two flops before anyone looks at it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_m <= 1'b0;
      ext_s <= 1'b0;
    end else begin
      ext_m <= ext_rst_req;
      ext_s <= ext_m;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    sw_pending_nx = sw_pending;
    // a request can only be served again after it has been seen low
    sw_armed_nx   = sw_armed | ~sw_rst_req;
    done_nx       = 1'b0;
    ack_nx        = 1'b0;
    case (state)
      HOLD: begin
        if (ext_s) begin
          cnt_nx = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nx = POST;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      POST: begin
        if (ext_s) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else if (cnt == POST_LAST) begin
          state_nx      = RUN;
          cnt_nx        = '0;
          done_nx       = 1'b1;
          ack_nx        = sw_pending;
          sw_pending_nx = 1'b0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      RUN: begin
        // a software request coinciding with ext_s still gets its ack
        if (sw_rst_req && sw_armed) begin
          sw_pending_nx = 1'b1;
          sw_armed_nx   = 1'b0;
        end
        if (ext_s || (sw_rst_req && sw_armed)) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = HOLD;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HOLD;
      cnt        <= '0;
      sw_pending <= 1'b0;
      sw_armed   <= 1'b1;
      rst_done   <= 1'b0;
      sw_rst_ack <= 1'b0;
      rst_count  <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sw_pending <= sw_pending_nx;
      sw_armed   <= sw_armed_nx;
      rst_done   <= done_nx;
      sw_rst_ack <= ack_nx;
      if (done_nx) rst_count <= rst_count + CNT_W'(1);
    end
  end

  assign core_rst   = (state == HOLD);
  assign core_ready = (state == RUN);

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: a deadline-based episode model checked every cycle, plus
// directed scenarios with hand-computed cycle positions and counts.
module tb_rst_seq;
  localparam int HOLD = 16;
  localparam int POST = 4;

  logic       clk, rst_n, ext_rst_req, sw_rst_req;
  logic       sw_rst_ack, core_rst, core_ready, rst_done;
  logic [7:0] rst_count;
  logic       sw_rst_ack_w, core_rst_w, core_ready_w, rst_done_w;
  logic [1:0] rst_count_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model: an episode is "open" from its anchor edge; core_rst falls HOLD edges
  // after the last anchor, and the episode completes HOLD+POST edges after it
  bit m_valid = 1'b0;
  bit m_ep, m_pend, m_armed, m_done, m_ack, m_s, m_take;
  bit x_hist [2];
  int m_anchor, m_last, m_count;

  int hi, rdy_at, dones, done_at, acks, ack_at;
  int hi2, rdy2, dones2, done2, acks2, ack2;
  int exp_w [4] = '{2, 3, 0, 1};

  rst_seq #(.HOLD_CYCLES(HOLD), .POST_CYCLES(POST), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ext_rst_req(ext_rst_req), .sw_rst_req(sw_rst_req),
    .sw_rst_ack(sw_rst_ack), .core_rst(core_rst), .core_ready(core_ready),
    .rst_done(rst_done), .rst_count(rst_count)
  );

  rst_seq #(.HOLD_CYCLES(HOLD), .POST_CYCLES(POST), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .ext_rst_req(ext_rst_req), .sw_rst_req(sw_rst_req),
    .sw_rst_ack(sw_rst_ack_w), .core_rst(core_rst_w), .core_ready(core_ready_w),
    .rst_done(rst_done_w), .rst_count(rst_count_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model, advanced on every rising edge
  initial forever begin
    @(posedge clk);
    m_last = cyc;
    if (!rst_n) begin
      m_valid = 1'b1; m_ep = 1'b1; m_anchor = cyc; m_pend = 1'b0; m_armed = 1'b1;
      m_count = 0; m_done = 1'b0; m_ack = 1'b0; x_hist[0] = 1'b0; x_hist[1] = 1'b0;
    end else begin
      m_s = x_hist[1];
      m_take = 1'b0;
      m_done = 1'b0;
      m_ack = 1'b0;
      if (m_ep) begin
        if (m_s) m_anchor = cyc;
        else if (cyc == m_anchor + HOLD + POST) begin
          m_ep = 1'b0; m_done = 1'b1; m_count++;
          if (m_pend) begin m_ack = 1'b1; m_pend = 1'b0; end
        end
      end else if (m_s || (sw_rst_req && m_armed)) begin
        m_ep = 1'b1; m_anchor = cyc;
        if (sw_rst_req && m_armed) begin m_pend = 1'b1; m_take = 1'b1; end
      end
      if (m_take) m_armed = 1'b0;
      else if (!sw_rst_req) m_armed = 1'b1;
      x_hist[1] = x_hist[0];
      x_hist[0] = ext_rst_req;
    end
    cyc++;
  end

  // per-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("core_rst", int'(core_rst), (m_ep && (m_last - m_anchor < HOLD)) ? 1 : 0);
      chk("core_ready", int'(core_ready), m_ep ? 0 : 1);
      chk("rst_done", int'(rst_done), int'(m_done));
      chk("sw_rst_ack", int'(sw_rst_ack), int'(m_ack));
      chk("rst_count", int'(rst_count), m_count % 256);
      chk("core_rst_w", int'(core_rst_w), (m_ep && (m_last - m_anchor < HOLD)) ? 1 : 0);
      chk("core_ready_w", int'(core_ready_w), m_ep ? 0 : 1);
      chk("rst_done_w", int'(rst_done_w), int'(m_done));
      chk("sw_rst_ack_w", int'(sw_rst_ack_w), int'(m_ack));
      chk("rst_count_w", int'(rst_count_w), m_count % 4);
    end
  end

  // sample n consecutive negedges, numbering the first one j0
  task automatic watch(input int j0, input int n, output int o_hi, output int o_rdy,
                       output int o_dones, output int o_done_at, output int o_acks,
                       output int o_ack_at);
    o_hi = 0; o_rdy = -1; o_dones = 0; o_done_at = -1; o_acks = 0; o_ack_at = -1;
    for (int j = j0; j < j0 + n; j++) begin
      if (core_rst) o_hi++;
      if (core_ready && o_rdy < 0) o_rdy = j;
      if (rst_done) begin o_dones++; if (o_done_at < 0) o_done_at = j; end
      if (sw_rst_ack) begin o_acks++; if (o_ack_at < 0) o_ack_at = j; end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; ext_rst_req = 1'b0; sw_rst_req = 1'b0;

    // power-on
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_core_rst", int'(core_rst), 1);
    chk("reset_core_ready", int'(core_ready), 0);
    chk("reset_count", int'(rst_count), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    watch(0, 25, hi, rdy_at, dones, done_at, acks, ack_at);
    chk("po_hold_len", hi, 16);
    chk("po_ready_at", rdy_at, 20);
    chk("po_done_at", done_at, 20);
    chk("po_dones", dones, 1);
    chk("po_count", int'(rst_count), 1);

    // software request held through and past the ack
    sw_rst_req = 1'b1;
    @(negedge clk);
    watch(1, 30, hi, rdy_at, dones, done_at, acks, ack_at);
    chk("sw_hold_len", hi, 16);
    chk("sw_ack_at", ack_at, 21);
    chk("sw_acks", acks, 1);
    watch(1, 10, hi, rdy_at, dones, done_at, acks, ack_at);
    chk("sw_no_retrigger", hi + acks + dones, 0);
    chk("sw_count", int'(rst_count), 2);
    sw_rst_req = 1'b0;
    @(negedge clk);
    sw_rst_req = 1'b1;
    @(negedge clk);
    watch(1, 30, hi, rdy_at, dones, done_at, acks, ack_at);
    chk("sw2_ack_at", ack_at, 21);
    chk("sw2_count", int'(rst_count), 3);
    sw_rst_req = 1'b0;
    @(negedge clk);

    // external request held 30 cycles in RUN
    ext_rst_req = 1'b1;
    watch(0, 30, hi, rdy_at, dones, done_at, acks, ack_at);
    ext_rst_req = 1'b0;
    watch(0, 40, hi2, rdy2, dones2, done2, acks2, ack2);
    chk("ext_acks", acks + acks2, 0);
    chk("ext_dones", dones + dones2, 1);
    chk("ext_count", int'(rst_count), 4);

    // external pulse during POST of a software episode
    sw_rst_req = 1'b1;
    @(negedge clk);
    watch(1, 16, hi, rdy_at, dones, done_at, acks, ack_at);
    ext_rst_req = 1'b1;
    watch(17, 1, hi2, rdy2, dones2, done2, acks2, ack2);
    ext_rst_req = 1'b0;
    watch(18, 40, hi, rdy_at, dones, done_at, acks, ack_at);
    chk("post_rehold_len", hi, 16);
    chk("post_done_at", done_at, 40);
    chk("post_ack_at", ack_at, 40);
    chk("post_dones", dones + dones2, 1);
    chk("post_count", int'(rst_count), 5);
    sw_rst_req = 1'b0;
    @(negedge clk);

    // software and external requests together
    sw_rst_req = 1'b1;
    ext_rst_req = 1'b1;
    @(negedge clk);
    watch(1, 3, hi, rdy_at, dones, done_at, acks, ack_at);
    ext_rst_req = 1'b0;
    watch(4, 40, hi2, rdy2, dones2, done2, acks2, ack2);
    chk("coll_dones", dones + dones2, 1);
    chk("coll_acks", acks + acks2, 1);
    chk("coll_done_at", done2, 26);
    chk("coll_count", int'(rst_count), 6);
    sw_rst_req = 1'b0;
    @(negedge clk);

    // rst_n mid-HOLD of a software episode
    sw_rst_req = 1'b1;
    @(negedge clk);
    watch(1, 5, hi, rdy_at, dones, done_at, acks, ack_at);
    rst_n = 1'b0;
    sw_rst_req = 1'b0;
    @(negedge clk);
    chk("midrst_core_rst", int'(core_rst), 1);
    chk("midrst_count", int'(rst_count), 0);
    chk("midrst_count_w", int'(rst_count_w), 0);
    rst_n = 1'b1;
    watch(0, 30, hi, rdy_at, dones, done_at, acks, ack_at);
    chk("midrst_no_ack", acks, 0);
    chk("midrst_ready_at", rdy_at, 20);

    // narrow counter wraps: 1 after power-on, then 2,3,0,1
    chk("wrap_0", int'(rst_count_w), 1);
    for (int e = 0; e < 4; e++) begin
      sw_rst_req = 1'b1;
      @(negedge clk);
      watch(1, 25, hi, rdy_at, dones, done_at, acks, ack_at);
      sw_rst_req = 1'b0;
      @(negedge clk);
      chk("wrap_seq", int'(rst_count_w), exp_w[e]);
    end

    // randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 8) sw_rst_req = ~sw_rst_req;
      if ($urandom_range(0, 99) < 3) ext_rst_req = 1'b1;
      else if ($urandom_range(0, 99) < 30) ext_rst_req = 1'b0;
      rst_n = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
